// File: rtl/srlatch_cmd_arbiter.sv
// Round-robin arbiter that sequences set/clear commands onto a bank of enable-gated
// SR latches (setup -> strobe -> hold) and keeps a registered shadow of the bank.
module srlatch_cmd_arbiter #(
  parameter int NREQ          = 4,
  parameter int NBIT          = 8,
  parameter int IDXW          = 3,
  parameter int STROBE_CYCLES = 1,
  localparam int IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic [NBIT-1:0]      lat_e,
  output logic [NBIT-1:0]      lat_s,
  output logic [NBIT-1:0]      lat_r,
  output logic [NBIT-1:0]      shadow
);

  localparam int CNTW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t            state, state_next;
  logic [IDW-1:0]    rr_ptr, rr_next, id_next, win;
  logic              cur_op, op_next, sel_op, found;
  logic [IDXW-1:0]   cur_idx, idx_next, sel_idx;
  logic [CNTW-1:0]   cnt, cnt_next;
  logic [NBIT-1:0]   mask_cur, mask_next, shadow_next, e_next, s_next, r_next;
  logic [NREQ-1:0]   ack_next;
  logic              err_next;

  // Round-robin search: first pass covers rr_ptr..NREQ-1, second pass wraps to 0.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    sel_op  = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && i >= int'(rr_ptr)) begin
        found   = 1'b1;
        win     = IDW'(i);
        sel_op  = op[i];
        sel_idx = idx[i*IDXW +: IDXW];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        win     = IDW'(i);
        sel_op  = op[i];
        sel_idx = idx[i*IDXW +: IDXW];
      end
    end
  end

  always_comb begin
    state_next  = state;
    rr_next     = rr_ptr;
    id_next     = grant_id;
    op_next     = cur_op;
    idx_next    = cur_idx;
    cnt_next    = cnt;
    ack_next    = '0;
    err_next    = 1'b0;
    shadow_next = shadow;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = SETUP;
          rr_next    = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
          id_next    = win;
          op_next    = sel_op;
          idx_next   = sel_idx;
        end
      end
      SETUP: begin
        cnt_next   = '0;
        // An out-of-range index has an all-zero mask and skips the strobe.
        state_next = (|mask_cur) ? STROBE : HOLD;
      end
      STROBE: begin
        if (cnt == CNTW'(STROBE_CYCLES - 1)) state_next = HOLD;
        else                                 cnt_next   = cnt + 1'b1;
      end
      HOLD: begin
        state_next = IDLE;
        for (int i = 0; i < NREQ; i++) begin
          if (int'(grant_id) == i) ack_next[i] = 1'b1;
        end
        err_next    = ~|mask_cur;
        shadow_next = cur_op ? (shadow | mask_cur) : (shadow & ~mask_cur);
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch drives are decoded from the next state so they register with it;
  // s and r come from one op bit, so they can never both be high.
  always_comb begin
    for (int b = 0; b < NBIT; b++) begin
      mask_cur[b]  = (int'(cur_idx) == b);
      mask_next[b] = (int'(idx_next) == b);
    end
    e_next = (state_next == STROBE) ? mask_next : '0;
    s_next = (state_next != IDLE && op_next)  ? mask_next : '0;
    r_next = (state_next != IDLE && !op_next) ? mask_next : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      cnt      <= '0;
      grant_id <= '0;
      ack      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      lat_e    <= '0;
      lat_s    <= '0;
      lat_r    <= '0;
      shadow   <= '0;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_next;
      cnt      <= cnt_next;
      grant_id <= id_next;
      ack      <= ack_next;
      err      <= err_next;
      busy     <= (state_next != IDLE);
      lat_e    <= e_next;
      lat_s    <= s_next;
      lat_r    <= r_next;
      shadow   <= shadow_next;
    end
  end

  always_ff @(posedge clk) begin
    cur_op  <= op_next;
    cur_idx <= idx_next;
  end

endmodule

// File: tb/tb_srlatch_cmd_arbiter.sv
// Scoreboard bench for srlatch_cmd_arbiter: directed accesses, round-robin, async reset,
// out-of-range indices on a 6-bit bank, and a randomized run against a shadow model.
module tb_srlatch_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req, op, ack;
  logic [11:0] idx;
  logic        err, busy;
  logic [1:0]  grant_id;
  logic [7:0]  lat_e, lat_s, lat_r, shadow;

  logic [1:0]  req6, op6, ack6;
  logic [5:0]  idx6, e6, s6, r6, sh6;
  logic        err6, busy6;
  logic [0:0]  grant6;

  always #5 clk = ~clk;

  srlatch_cmd_arbiter #(.NREQ(4), .NBIT(8), .IDXW(3), .STROBE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx), .ack(ack), .err(err),
    .busy(busy), .grant_id(grant_id), .lat_e(lat_e), .lat_s(lat_s), .lat_r(lat_r),
    .shadow(shadow));

  srlatch_cmd_arbiter #(.NREQ(2), .NBIT(6), .IDXW(3), .STROBE_CYCLES(1)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .req(req6), .op(op6), .idx(idx6), .ack(ack6), .err(err6),
    .busy(busy6), .grant_id(grant6), .lat_e(e6), .lat_s(s6), .lat_r(r6), .shadow(sh6));

  typedef struct {int id; bit err; logic [7:0] sh;} exp_t;
  exp_t exp_q[$];

  int         total = 0;
  int         passed = 0;
  int         rand_acks = 0;
  bit         rand_mode = 1'b0;
  bit         pend[4];
  bit         pend_op[4];
  int         pend_idx[4];
  logic [7:0] model_sh = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: latch invariants every cycle, scoreboard/model compare on each ack.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("lat_invariant", ((lat_s & lat_r) == 0) && $onehot0(lat_e) &&
            $onehot0(lat_s | lat_r) && ((lat_e & ~(lat_s | lat_r)) == 0), 1);
      check("lat6_invariant", ((s6 & r6) == 0) && $onehot0(e6) && $onehot0(s6 | r6), 1);
      if (ack != 0) begin
        if (!rand_mode) begin
          if (exp_q.size() == 0) check("unexpected_ack", ack, 0);
          else begin
            e = exp_q.pop_front();
            check("sb_ack", ack, 32'(1) << e.id);
            check("sb_err", err, e.err);
            check("sb_shadow", shadow, e.sh);
          end
        end else begin
          rand_acks++;
          check("rand_ack_onehot", $onehot(ack), 1);
          for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
              check("rand_ack_pending", pend[i], 1);
              if (pend[i]) model_sh[pend_idx[i]] = pend_op[i];
            end
          end
          check("rand_err", err, 0);
          check("rand_shadow", shadow, model_sh);
        end
      end
    end
  end

  // One full access on the 8-bit bank, starting from IDLE.
  task automatic access(int id, bit o, int ix, logic [7:0] exp_sh);
    logic [7:0] m;
    m = 8'(1 << ix);
    exp_q.push_back(exp_t'{id, 1'b0, exp_sh});
    req[id] = 1'b1; op[id] = o; idx[id*3 +: 3] = 3'(ix);
    tick(1);
    check("setup_e", lat_e, 0);
    check("setup_s", lat_s, o ? m : 8'h00);
    check("setup_r", lat_r, o ? 8'h00 : m);
    check("setup_busy_id", {busy, grant_id}, {1'b1, 2'(id)});
    tick(1);
    check("strobe_e", lat_e, m);
    check("strobe_sr", {lat_s, lat_r}, o ? {m, 8'h00} : {8'h00, m});
    tick(1);
    check("hold_e_ack", {lat_e, ack}, {m, 4'h0} & 12'h00f);
    check("hold_sr", {lat_s, lat_r}, o ? {m, 8'h00} : {8'h00, m});
    tick(1);
    check("ack_latency", ack, 32'(1) << id);
    check("idle_outputs", {busy, lat_e, lat_s, lat_r}, 0);
    req[id] = 1'b0;
  endtask

  task automatic acc6(int ix, bit o, bit exp_err, logic [5:0] exp_sh, int exp_lat);
    logic [5:0] seen;
    int n;
    seen = '0; n = 0;
    req6[0] = 1'b1; op6[0] = o; idx6[2:0] = 3'(ix);
    while (ack6 == 0 && n < 10) begin
      tick(1);
      n++;
      seen |= e6 | s6 | r6;
    end
    req6[0] = 1'b0;
    check("d6_latency", n, exp_lat);
    check("d6_ack", ack6, 1);
    check("d6_err", err6, exp_err);
    check("d6_shadow", sh6, exp_sh);
    check("d6_lat_activity", seen, exp_err ? 6'h00 : 6'(1 << ix));
  endtask

  initial begin
    int n_ack, last;
    bit renew0;
    req = '0; op = '0; idx = '0; req6 = '0; op6 = '0; idx6 = '0;
    for (int i = 0; i < 4; i++) begin pend[i] = 0; pend_op[i] = 0; pend_idx[i] = 0; end
    tick(3);
    check("rst_ctrl", {ack, err, busy, grant_id}, 0);
    check("rst_lat", {lat_e, lat_s, lat_r, shadow}, 0);
    rst_n = 1'b1;
    tick(1);

    access(1, 1'b1, 5, 8'h20);
    access(2, 1'b0, 5, 8'h00);
    access(3, 1'b1, 6, 8'h40);

    // Reset in the middle of a strobe; this access never acks.
    req[0] = 1'b1; op[0] = 1'b1; idx[2:0] = 3'd2;
    tick(2);
    check("pre_rst_strobe", lat_e, 8'h04);
    rst_n = 1'b0;
    #1;
    check("rst_async_lat", {lat_e, lat_s, lat_r}, 0);
    check("rst_async_state", {busy, ack, err, shadow}, 0);
    req[0] = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Round robin with all four requesting; requester 0 renews once.
    op  = 4'b1011;
    idx = {3'd7, 3'd0, 3'd1, 3'd0};
    exp_q.push_back(exp_t'{0, 1'b0, 8'h01});
    exp_q.push_back(exp_t'{1, 1'b0, 8'h03});
    exp_q.push_back(exp_t'{2, 1'b0, 8'h02});
    exp_q.push_back(exp_t'{3, 1'b0, 8'h82});
    exp_q.push_back(exp_t'{0, 1'b0, 8'h83});
    req = 4'hF;
    n_ack = 0; last = -1; renew0 = 1'b1;
    for (int cyc = 0; cyc < 40 && n_ack < 5; cyc++) begin
      tick(1);
      if (ack != 0) begin
        if (last >= 0) check("rr_spacing", cyc - last, 4);
        else           check("rr_first_latency", cyc, 3);
        last = cyc;
        n_ack++;
        for (int i = 0; i < 4; i++) begin
          if (ack[i]) begin
            if (i == 0 && renew0) renew0 = 1'b0;
            else req[i] = 1'b0;
          end
        end
      end
    end
    check("rr_ack_count", n_ack, 5);
    req = '0;
    tick(2);

    acc6(3, 1'b1, 1'b0, 6'h08, 4);
    tick(1);
    acc6(7, 1'b1, 1'b1, 6'h08, 3);
    tick(1);
    acc6(6, 1'b0, 1'b1, 6'h08, 3);
    tick(1);
    acc6(5, 1'b1, 1'b0, 6'h28, 4);
    tick(1);
    check("sb_drained", exp_q.size(), 0);

    // Randomized traffic against the shadow model.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    model_sh = '0;
    rand_mode = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #7;
      for (int i = 0; i < 4; i++) begin
        if (pend[i] && ack[i]) begin
          pend[i] = 1'b0;
          req[i]  = 1'b0;
        end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]     = 1'b1;
          pend_op[i]  = 1'($urandom_range(0, 1));
          pend_idx[i] = int'($urandom_range(0, 7));
          req[i]      = 1'b1;
          op[i]       = pend_op[i];
          idx[i*3 +: 3] = 3'(pend_idx[i]);
        end
      end
    end
    req = '0;
    tick(12);
    check("rand_progress", rand_acks > 100, 1);
    check("rand_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
